// File: rtl/note_sequencer.sv
// Song sequencer: walks a song ROM and hands tone half-periods to a tone generator.
// Optional inter-note silence is compiled in with `define NOTE_GAP_EN.
module note_sequencer #(
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned SONG_LEN    = 92,
    parameter int unsigned GAP_CYCLES  = 625000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        loop_en,
    output logic [6:0]  rom_addr,
    input  logic [5:0]  rom_data,
    output logic [31:0] half_period,
    output logic        note_valid,
    input  logic        note_ready,
    output logic        busy,
    output logic        song_done
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StIssue, StHold, StGap, StStop, StDone
    } state_e;

    localparam logic [6:0] LastIdx = 7'(SONG_LEN - 1);

    state_e      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] half_q, half_d;
    logic [1:0]  len_q, len_d;
    logic        stop_done_q, stop_done_d;
    logic        song_done_q, song_done_d;
    logic        gap_sent_q, gap_sent_d;

    logic [31:0] full_len;
    logic [31:0] hold_len;
    logic        go_stop;
    logic        advance;

    function automatic logic [31:0] pitch_lut(input logic [3:0] code);
        logic [31:0] hp;
        case (code)
            4'd1:    hp = 32'd47778;
            4'd2:    hp = 32'd42565;
            4'd3:    hp = 32'd37921;
            4'd4:    hp = 32'd35793;
            4'd5:    hp = 32'd31888;
            4'd6:    hp = 32'd28409;
            4'd7:    hp = 32'd25309;
            4'd8:    hp = 32'd23889;
            4'd9:    hp = 32'd17896;
            default: hp = 32'd0;
        endcase
        return hp;
    endfunction

    always_comb begin
        full_len = ({30'd0, len_q} + 32'd1) * BEAT_CYCLES;
`ifdef NOTE_GAP_EN
        // Silence is carved out of the note's own slot so the beat grid is kept.
        hold_len = (full_len > 32'(GAP_CYCLES)) ? full_len - 32'(GAP_CYCLES) : 32'd1;
`else
        hold_len = full_len;
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        len_d       = len_q;
        stop_done_d = stop_done_q;
        song_done_d = 1'b0;
        gap_sent_d  = gap_sent_q;
        go_stop     = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (play) state_d = StAddr;
            end
            StAddr: begin
                if (!play) go_stop = 1'b1;
                else       state_d = StData;
            end
            StData: begin
                if (!play) begin
                    go_stop = 1'b1;
                end else begin
                    half_d  = pitch_lut(rom_data[5:2]);
                    len_d   = rom_data[1:0];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // A pending offer is always completed before reacting to play.
                if (note_ready) begin
                    cnt_d = 32'd0;
                    if (!play) go_stop = 1'b1;
                    else       state_d = StHold;
                end
            end
            StHold: begin
                if (!play) begin
                    go_stop = 1'b1;
                end else if (({1'b0, cnt_q} + 33'd1) >= {1'b0, hold_len}) begin
`ifdef NOTE_GAP_EN
                    state_d    = StGap;
                    cnt_d      = 32'd0;
                    half_d     = 32'd0;
                    gap_sent_d = 1'b0;
`else
                    advance = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StGap: begin
                if (!play) begin
                    go_stop = 1'b1;
                end else if (!gap_sent_q) begin
                    if (note_ready) gap_sent_d = 1'b1;
                    cnt_d = 32'd0;
                end else if (({1'b0, cnt_q} + 33'd1) >= {1'b0, 32'(GAP_CYCLES)}) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStop: begin
                if (note_ready) state_d = stop_done_q ? StDone : StIdle;
            end
            StDone: begin
                if (!play) begin
                    state_d = StIdle;
                    idx_d   = 7'd0;
                end
            end
        endcase

        if (advance) begin
            cnt_d = 32'd0;
            if (idx_q == LastIdx) begin
                song_done_d = 1'b1;
                if (loop_en) begin
                    idx_d   = 7'd0;
                    state_d = StAddr;
                end else begin
                    state_d     = StStop;
                    half_d      = 32'd0;
                    stop_done_d = 1'b1;
                end
            end else begin
                idx_d   = idx_q + 7'd1;
                state_d = StAddr;
            end
        end

        // idx is kept so playback resumes at the interrupted entry.
        if (go_stop) begin
            state_d     = StStop;
            half_d      = 32'd0;
            cnt_d       = 32'd0;
            stop_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 7'd0;
            cnt_q       <= 32'd0;
            half_q      <= 32'd0;
            len_q       <= 2'd0;
            stop_done_q <= 1'b0;
            song_done_q <= 1'b0;
            gap_sent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            len_q       <= len_d;
            stop_done_q <= stop_done_d;
            song_done_q <= song_done_d;
            gap_sent_q  <= gap_sent_d;
        end
    end

    assign rom_addr    = idx_q;
    assign half_period = half_q;
    assign song_done   = song_done_q;
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign note_valid  = (state_q == StIssue) || (state_q == StStop) ||
                         ((state_q == StGap) && !gap_sent_q);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected transfers are queued by the stimulus
// and checked (value and spacing) by an independent monitor.
`timescale 1ns/1ps
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic        loop_en = 1'b0;
    logic [6:0]  rom_addr;
    logic [5:0]  rom_data = 6'd0;
    logic [31:0] half_period;
    logic        note_valid;
    logic        note_ready = 1'b1;
    logic        busy;
    logic        song_done;

    typedef struct {
        logic [31:0] hp;
        int          delta;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   ncyc = 0;
    int   last_xfer = 0;
    int   n_song_done = 0;

    always #5 clk = ~clk;

    note_sequencer #(
        .BEAT_CYCLES(4),
        .SONG_LEN(3),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .play(play),
        .loop_en(loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .half_period(half_period),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .busy(busy),
        .song_done(song_done)
    );

    // Synchronous ROM: E5 len0, rest len1, C6 len3
    always @(posedge clk) begin
        case (rom_addr)
            7'd0:    rom_data <= 6'b001100;
            7'd1:    rom_data <= 6'b000001;
            7'd2:    rom_data <= 6'b100011;
            default: rom_data <= 6'b000000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out, got no event expected event (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [31:0] hp, input int delta);
        exp_t e;
        e.hp = hp;
        e.delta = delta;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            timeout("drain");
            sb.delete();
        end
    endtask

    task automatic wait_song_done(input int budget);
        int i;
        for (i = 0; i < budget && song_done !== 1'b1; i++) step(1);
        if (song_done !== 1'b1) timeout("song_done");
    endtask

    // Monitor: checks every transfer against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (song_done === 1'b1) n_song_done++;
            if (note_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    if (note_ready === 1'b1) begin
                        n_checks++;
                        $display("FAIL spurious_xfer: got hp=%0d expected no transfer", half_period);
                    end
                end else if (note_ready === 1'b1) begin
                    e = sb.pop_front();
                    check("xfer_hp", half_period, e.hp);
                    if (e.delta >= 0) check("xfer_spacing", ncyc - last_xfer, e.delta);
                    last_xfer = ncyc;
                end else begin
                    check("stall_hp", half_period, sb[0].hp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_valid", note_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", song_done, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_hp", half_period, 0);
        rst_n = 1'b1;
        step(2);

        // Full song, no loop
        push(37921, -1);
        push(0, 7);
        push(23889, 11);
        push(0, 17);
        play = 1'b1;
        step(1);
        check("addr_state_valid", note_valid, 0);
        check("addr_state_busy", busy, 1);
        check("addr_state_addr", rom_addr, 0);
        step(1);
        check("data_state_valid", note_valid, 0);
        step(1);
        check("issue_valid", note_valid, 1);
        check("issue_hp", half_period, 37921);
        wait_drain(100);
        check("done_busy", busy, 0);
        check("done_valid", note_valid, 0);
        check("song_done_once", n_song_done, 1);
        step(20);
        check("no_restart_busy", busy, 0);
        check("no_restart_addr", rom_addr, 2);
        play = 1'b0;
        step(1);
        check("idle_idx_cleared", rom_addr, 0);
        step(2);

        // Looping song, then play drop mid-HOLD of entry 2
        loop_en = 1'b1;
        push(37921, -1);
        push(0, 7);
        push(23889, 11);
        push(37921, 19);
        push(0, 7);
        play = 1'b1;
        wait_song_done(100);
        check("loop_addr", rom_addr, 0);
        check("loop_busy", busy, 1);
        wait_drain(100);
        push(23889, 11);
        wait_drain(100);
        loop_en = 1'b0;
        step(5);
        push(0, -1);
        play = 1'b0;
        wait_drain(20);
        check("drop_busy", busy, 0);
        check("drop_keep_idx", rom_addr, 2);
        push(23889, -1);
        push(0, 17);
        play = 1'b1;
        step(1);
        check("resume_addr", rom_addr, 2);
        wait_drain(100);
        check("song_done_total", n_song_done, 3);
        play = 1'b0;
        step(3);

        // Back-pressure in ISSUE
        note_ready = 1'b0;
        push(37921, -1);
        push(0, 7);
        play = 1'b1;
        step(3);
        check("stall_valid", note_valid, 1);
        step(7);
        note_ready = 1'b1;
        wait_drain(50);

        // Reset during HOLD
        step(2);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        step(1);
        check("rst2_valid", note_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_hp", half_period, 0);
        check("rst2_addr", rom_addr, 0);
        check("rst2_done", song_done, 0);
        push(37921, -1);
        rst_n = 1'b1;
        wait_drain(20);
        push(0, -1);
        play = 1'b0;
        wait_drain(20);
        check("end_busy", busy, 0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
